// File: rtl/cache_flush_sequencer.sv
// cache_flush_sequencer
//   Per-bank whole-cache maintenance controller. After reset it walks every
//   line issuing init ops. On a flush request it locks the core side, waits
//   for the bank to drain, walks every line (and every way in writeback mode)
//   issuing flush ops, waits for the bank to drain again, then raises the
//   flush response.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush_req_*         flush request handshake (accepted only in IDLE)
//   flush_rsp_*         flush completion handshake
//   bank_idle           bank pipeline/MSHR/write queue empty
//   core_lock           bank must not accept core requests
//   op_*                maintenance op valid/ready port into the bank
//   busy                sequencer not in IDLE
//
// State | meaning
// ------+---------------------------------------------------------------
// INIT       | walking all lines with init ops after reset
// IDLE       | waiting for a flush request, core traffic allowed
// DRAIN_PRE  | core locked, waiting for the bank to go idle
// FLUSH      | walking lines (and ways in writeback mode) with flush ops
// DRAIN_POST | minimum wait plus waiting for the bank to go idle again
// RESP       | flush response held until consumed
module cache_flush_sequencer #(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_SIZE  = 16,
  parameter int NUM_BANKS  = 1,
  parameter int NUM_WAYS   = 1,
  parameter int WRITEBACK  = 0,
  localparam int LINES         = CACHE_SIZE / (LINE_SIZE * NUM_WAYS * NUM_BANKS),
  localparam int LINE_SEL_BITS = (LINES > 1) ? $clog2(LINES) : 1,
  localparam int WAY_SEL_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_req_valid,
  output logic                     flush_req_ready,
  output logic                     flush_rsp_valid,
  input  logic                     flush_rsp_ready,
  input  logic                     bank_idle,
  output logic                     core_lock,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic                     op_init,
  output logic                     op_flush,
  output logic [LINE_SEL_BITS-1:0] op_line_idx,
  output logic [WAY_SEL_WIDTH-1:0] op_way,
  output logic                     busy
);

  localparam logic [LINE_SEL_BITS-1:0] LINE_LAST = LINE_SEL_BITS'(LINES - 1);
  localparam logic [WAY_SEL_WIDTH-1:0] WAY_LAST  = WAY_SEL_WIDTH'(NUM_WAYS - 1);
  localparam bit                       WALK_WAYS = (WRITEBACK != 0) && (NUM_WAYS > 1);
  // Down-counter loaded on entry to DRAIN_POST; the first DRAIN_POST cycle
  // plus one counted cycle gives the two-cycle minimum before bank_idle is
  // trusted (bank_idle is registered inside the bank).
  localparam logic [1:0]               DRAIN_MIN = 2'd1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRAIN_PRE,
    S_FLUSH,
    S_DRAIN_POST,
    S_RESP
  } state_t;

  state_t                   state, state_nxt;
  logic [LINE_SEL_BITS-1:0] line, line_nxt;
  logic [WAY_SEL_WIDTH-1:0] way, way_nxt;
  logic [1:0]               timer, timer_nxt;
  logic                     op_fire;

  // op_valid is the registered output, so the cycle right after reset
  // (op_valid still 0) can never count as a handshake.
  assign op_fire = op_valid && op_ready;

  always_comb begin
    state_nxt = state;
    line_nxt  = line;
    way_nxt   = way;
    timer_nxt = timer;
    case (state)
      S_INIT: begin
        if (op_fire) begin
          if (line == LINE_LAST) begin
            line_nxt  = '0;
            state_nxt = S_IDLE;
          end else begin
            line_nxt = line + 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (flush_req_valid) state_nxt = S_DRAIN_PRE;
      end
      S_DRAIN_PRE: begin
        if (bank_idle) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (op_fire) begin
          if (WALK_WAYS && (way != WAY_LAST)) begin
            way_nxt = way + 1'b1;
          end else begin
            way_nxt = '0;
            if (line == LINE_LAST) begin
              line_nxt  = '0;
              timer_nxt = DRAIN_MIN;
              state_nxt = S_DRAIN_POST;
            end else begin
              line_nxt = line + 1'b1;
            end
          end
        end
      end
      S_DRAIN_POST: begin
        if (timer != 2'd0) begin
          timer_nxt = timer - 2'd1;
        end else if (bank_idle) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (flush_rsp_ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_INIT;
        line_nxt  = '0;
        way_nxt   = '0;
        timer_nxt = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register without any input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_INIT;
      line            <= '0;
      way             <= '0;
      timer           <= '0;
      op_valid        <= 1'b0;
      op_init         <= 1'b0;
      op_flush        <= 1'b0;
      op_line_idx     <= '0;
      op_way          <= '0;
      flush_req_ready <= 1'b0;
      flush_rsp_valid <= 1'b0;
      core_lock       <= 1'b1;
      busy            <= 1'b1;
    end else begin
      state           <= state_nxt;
      line            <= line_nxt;
      way             <= way_nxt;
      timer           <= timer_nxt;
      op_valid        <= (state_nxt == S_INIT) || (state_nxt == S_FLUSH);
      op_init         <= (state_nxt == S_INIT);
      op_flush        <= (state_nxt == S_FLUSH);
      op_line_idx     <= line_nxt;
      op_way          <= way_nxt;
      flush_req_ready <= (state_nxt == S_IDLE);
      flush_rsp_valid <= (state_nxt == S_RESP);
      core_lock       <= (state_nxt != S_IDLE);
      busy            <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// Bench for cache_flush_sequencer: a writeback 2-way instance (32 lines) and
// a writethrough 4-way instance (16 lines) with separate handshake inputs.
module tb_cache_flush_sequencer;

  localparam int CS = 1024;
  localparam int LS = 16;
  localparam int NB = 1;
  localparam int WB_WAYS  = 2;
  localparam int WB_LINES = CS / (LS * WB_WAYS * NB);
  localparam int WT_WAYS  = 4;
  localparam int WT_LINES = CS / (LS * WT_WAYS * NB);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
  logic       bank_idle = 1'b1, core_lock, op_valid, op_ready = 1'b1;
  logic       op_init, op_flush, busy;
  logic [4:0] op_line;
  logic [0:0] op_way;

  logic       wt_req_valid = 1'b0, wt_req_ready, wt_rsp_valid, wt_rsp_ready = 1'b1;
  logic       wt_bank_idle = 1'b1, wt_core_lock, wt_op_valid, wt_op_ready = 1'b1;
  logic       wt_op_init, wt_op_flush, wt_busy;
  logic [3:0] wt_op_line;
  logic [1:0] wt_op_way;

  cache_flush_sequencer #(
    .CACHE_SIZE(CS), .LINE_SIZE(LS), .NUM_BANKS(NB), .NUM_WAYS(WB_WAYS), .WRITEBACK(1)
  ) dut_wb (
    .clk(clk), .reset(reset),
    .flush_req_valid(req_valid), .flush_req_ready(req_ready),
    .flush_rsp_valid(rsp_valid), .flush_rsp_ready(rsp_ready),
    .bank_idle(bank_idle), .core_lock(core_lock),
    .op_valid(op_valid), .op_ready(op_ready), .op_init(op_init), .op_flush(op_flush),
    .op_line_idx(op_line), .op_way(op_way), .busy(busy)
  );

  cache_flush_sequencer #(
    .CACHE_SIZE(CS), .LINE_SIZE(LS), .NUM_BANKS(NB), .NUM_WAYS(WT_WAYS), .WRITEBACK(0)
  ) dut_wt (
    .clk(clk), .reset(reset),
    .flush_req_valid(wt_req_valid), .flush_req_ready(wt_req_ready),
    .flush_rsp_valid(wt_rsp_valid), .flush_rsp_ready(wt_rsp_ready),
    .bank_idle(wt_bank_idle), .core_lock(wt_core_lock),
    .op_valid(wt_op_valid), .op_ready(wt_op_ready), .op_init(wt_op_init), .op_flush(wt_op_flush),
    .op_line_idx(wt_op_line), .op_way(wt_op_way), .busy(wt_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: ops are expected strictly in walk order, so op k
  // of a flush targets line k / ways, way k % ways.
  int cyc = 0;
  int rdy_mode = 0;
  int init_idx = 0, flush_idx = 0, last_flush_cyc = 0;
  int wt_init_idx = 0, wt_flush_idx = 0, wt_last_cyc = 0;
  bit prev_stall = 1'b0;
  logic [8:0] prev_ops = '0;

  typedef struct {
    int         cyc;
    logic       op_valid;
    logic       op_init;
    logic [4:0] line;
    logic       req_ready;
    logic       core_lock;
    logic       wt_op_valid;
    logic       wt_req_ready;
  } init_vec_t;
  init_vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs on the falling edge, pick op_ready, and feed
  // any handshake that will occur at the next rising edge to the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    check("op_kind_exclusive", 64'(op_init & op_flush), 64'(0));
    if (!op_valid) check("op_kind_when_invalid", 64'({op_init, op_flush}), 64'(0));
    check("busy_vs_lock", 64'(busy), 64'(core_lock));
    check("lock_vs_req_ready", 64'(core_lock), 64'(!req_ready));
    if (prev_stall)
      check("stall_hold", 64'({op_valid, op_init, op_flush, op_line, op_way}), 64'(prev_ops));
    op_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (op_valid && op_ready) begin
      if (op_init) begin
        check("init_line", 64'(op_line), 64'(init_idx));
        check("init_way", 64'(op_way), 64'(0));
        init_idx++;
      end
      if (op_flush) begin
        check("flush_line", 64'(op_line), 64'(flush_idx / WB_WAYS));
        check("flush_way", 64'(op_way), 64'(flush_idx % WB_WAYS));
        flush_idx++;
        last_flush_cyc = cyc;
      end
    end
    prev_stall = op_valid && !op_ready;
    prev_ops   = {op_valid, op_init, op_flush, op_line, op_way};
    if (wt_op_valid && wt_op_ready) begin
      if (wt_op_init) begin
        check("wt_init_line", 64'(wt_op_line), 64'(wt_init_idx));
        wt_init_idx++;
      end
      if (wt_op_flush) begin
        check("wt_flush_line", 64'(wt_op_line), 64'(wt_flush_idx));
        check("wt_flush_way", 64'(wt_op_way), 64'(0));
        wt_flush_idx++;
        wt_last_cyc = cyc;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_valid"}, 64'(op_valid), 64'(0));
    check({tag, "_op_kind"}, 64'({op_init, op_flush}), 64'(0));
    check({tag, "_op_addr"}, 64'({op_line, op_way}), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_lock_busy"}, 64'({core_lock, busy}), 64'(3));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{2,  1'b1, 1'b1, 5'd1,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16, 1'b1, 1'b1, 5'd15, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{17, 1'b1, 1'b1, 5'd16, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{32, 1'b1, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{33, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};

    // Reset and init walk: cycle 0 is the reset-high cycle.
    reset = 1'b1;
    repeat (2) step();
    check_reset_outputs("reset");
    cyc = 0;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      while (cyc < tbl[i].cyc) step();
      check($sformatf("init_tbl%0d_op_valid", i), 64'(op_valid), 64'(tbl[i].op_valid));
      check($sformatf("init_tbl%0d_op_init", i), 64'(op_init), 64'(tbl[i].op_init));
      check($sformatf("init_tbl%0d_line", i), 64'(op_line), 64'(tbl[i].line));
      check($sformatf("init_tbl%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].req_ready));
      check($sformatf("init_tbl%0d_core_lock", i), 64'(core_lock), 64'(tbl[i].core_lock));
      check($sformatf("init_tbl%0d_wt_op_valid", i), 64'(wt_op_valid), 64'(tbl[i].wt_op_valid));
      check($sformatf("init_tbl%0d_wt_req_ready", i), 64'(wt_req_ready), 64'(tbl[i].wt_req_ready));
    end
    check("init_op_count", 64'(init_idx), 64'(WB_LINES));
    check("wt_init_op_count", 64'(wt_init_idx), 64'(WT_LINES));

    // Full-throughput writeback flush.
    rdy_mode = 0; bank_idle = 1'b1; rsp_ready = 1'b0; flush_idx = 0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("b_drain_pre_lock", 64'(core_lock), 64'(1));
    check("b_drain_pre_noop", 64'(op_valid), 64'(0));
    step();
    check("b_first_flush_op", 64'({op_valid, op_flush, op_line, op_way}), 64'({1'b1, 1'b1, 5'd0, 1'b0}));
    n = 0;
    while (flush_idx < WB_LINES * WB_WAYS && n < 300) begin
      check("b_core_lock_held", 64'(core_lock), 64'(1));
      step(); n++;
    end
    check("b_flush_op_count", 64'(flush_idx), 64'(WB_LINES * WB_WAYS));
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    check("b_rsp_seen", 64'(rsp_valid), 64'(1));
    check("b_rsp_latency", 64'(cyc - last_flush_cyc), 64'(3));
    repeat (2) begin
      step();
      check("b_rsp_held", 64'({rsp_valid, core_lock}), 64'(3));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("b_back_idle", 64'({rsp_valid, req_ready, core_lock}), 64'({1'b0, 1'b1, 1'b0}));
    check("b_no_extra_ops", 64'(flush_idx), 64'(WB_LINES * WB_WAYS));

    // Random op_ready stalls with bank_idle held low around the walk.
    flush_idx = 0; rdy_mode = 1; bank_idle = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (10) begin
      step();
      check("c_no_op_drain_pre", 64'(op_valid), 64'(0));
    end
    bank_idle = 1'b1;
    n = 0;
    while (flush_idx < WB_LINES * WB_WAYS && n < 2000) begin step(); n++; end
    bank_idle = 1'b0;
    check("c_flush_op_count", 64'(flush_idx), 64'(WB_LINES * WB_WAYS));
    repeat (10) begin
      step();
      check("c_rsp_waits_idle", 64'(rsp_valid), 64'(0));
    end
    bank_idle = 1'b1;
    step();
    check("c_rsp_after_idle", 64'(rsp_valid), 64'(1));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    rdy_mode = 0;
    check("c_back_idle", 64'(req_ready), 64'(1));
    check("c_no_extra_ops", 64'(flush_idx), 64'(WB_LINES * WB_WAYS));

    // Writethrough 4-way flush: one op per line, way always 0.
    wt_flush_idx = 0;
    wt_req_valid = 1'b1;
    step();
    wt_req_valid = 1'b0;
    n = 0;
    while (wt_flush_idx < WT_LINES && n < 100) begin step(); n++; end
    n = 0;
    while (!wt_rsp_valid && n < 20) begin step(); n++; end
    check("d_wt_rsp_seen", 64'(wt_rsp_valid), 64'(1));
    check("d_wt_rsp_latency", 64'(cyc - wt_last_cyc), 64'(3));
    step();
    check("d_wt_back_idle", 64'(wt_req_ready), 64'(1));
    repeat (3) step();
    check("d_wt_flush_op_count", 64'(wt_flush_idx), 64'(WT_LINES));

    // Request held through INIT, then reset on the 5th flush op.
    reset = 1'b1;
    step();
    check_reset_outputs("e_reset");
    init_idx = 0; flush_idx = 0; wt_init_idx = 0; wt_flush_idx = 0;
    cyc = 0;
    req_valid = 1'b1;
    reset = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin step(); n++; end
    check("e_accept_cycle", 64'(cyc), 64'(WB_LINES + 1));
    check("e_init_count", 64'(init_idx), 64'(WB_LINES));
    step();
    req_valid = 1'b0;
    check("e_drain_pre", 64'({core_lock, req_ready}), 64'({1'b1, 1'b0}));
    n = 0;
    while (flush_idx < 5 && n < 50) begin step(); n++; end
    check("e_fifth_op", 64'({op_flush, op_line, op_way}), 64'({1'b1, 5'd2, 1'b0}));
    reset = 1'b1;
    step();
    check_reset_outputs("e_abort");
    init_idx = 0; flush_idx = 0; wt_init_idx = 0;
    cyc = 0;
    reset = 1'b0;
    step();
    check("e_restart_op", 64'({op_valid, op_init, op_line}), 64'({1'b1, 1'b1, 5'd0}));
    repeat (39) begin
      step();
      check("e_no_rsp_after_abort", 64'(rsp_valid), 64'(0));
    end
    check("e_reinit_count", 64'(init_idx), 64'(WB_LINES));
    check("e_no_flush_after_abort", 64'(flush_idx), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
